player_input_router: RTL and testbench

PLAYER_INPUT_ROUTER -- requirements
Module: player_input_router

---
 rtl/player_input_pkg.sv | 64 ++++++
 rtl/input_event_fifo.sv | 53 +++++
 rtl/player_input_router.sv | 144 ++++++++++++++
 tb/tb_player_input_router.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/player_input_pkg.sv
// player_input_pkg: shared constants and helpers for the player input router.
//   - PS/2 prefix bytes (E0 extended, F0 break)
//   - 3-bit event codes delivered to each player's consumer
//   - keymap table and lookup: scan byte -> (player, direction)
package player_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [2:0] EVT_NONE  = 3'b000;
  localparam logic [2:0] EVT_UP    = 3'b001;
  localparam logic [2:0] EVT_LEFT  = 3'b010;
  localparam logic [2:0] EVT_DOWN  = 3'b011;
  localparam logic [2:0] EVT_RIGHT = 3'b100;
  localparam logic [2:0] EVT_SHAKE = 3'b110;

  typedef enum logic [1:0] {
    PS_IDLE      = 2'd0,
    PS_EXT       = 2'd1,
    PS_BREAK     = 2'd2,
    PS_EXT_BREAK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [1:0] dir;    // 0 up, 1 left, 2 down, 3 right
  } key_t;

  // Index = player*4 + direction.
  localparam logic [7:0] KEYMAP [16] = '{
    8'h1D, 8'h1C, 8'h1B, 8'h23,
    8'h75, 8'h6B, 8'h72, 8'h74,
    8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h2C, 8'h2B, 8'h34, 8'h33
  };

  function automatic key_t keymap_lookup(input logic [7:0] code);
    key_t       k;
    logic [3:0] idx;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (code == KEYMAP[i]) begin
        idx      = 4'(i);
        k.hit    = 1'b1;
        k.player = idx[3:2];
        k.dir    = idx[1:0];
      end
    end
    return k;
  endfunction

  function automatic logic [2:0] dir_to_evt(input logic [1:0] dir);
    logic [2:0] e;
    case (dir)
      2'd0:    e = EVT_UP;
      2'd1:    e = EVT_LEFT;
      2'd2:    e = EVT_DOWN;
      default: e = EVT_RIGHT;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/input_event_fifo.sv
// input_event_fifo: per-player event queue, oldest first.
//   clock, resetn         : clock, async active-low reset
//   push, push_data       : write request and event code
//   pop, pop_data         : read request and head-of-queue code
//   full, empty, count    : occupancy status (count is log2(DEPTH)+1 bits)
// A push while full is accepted only when a pop happens in the same cycle.
module input_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointer wrap is the natural binary rollover.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/player_input_router.sv
// player_input_router: parses a PS/2 scan byte stream and routes direction
// key presses into per-player event FIFOs.
//   clock, resetn        : clock, async active-low reset
//   scan_valid/scan_code : one-cycle strobe with the scan byte
//   evt_ready[p]         : consumer ready, pops on evt_valid && evt_ready
//   evt_valid[p]         : player p queue non-empty
//   evt_code[3p+2:3p]    : player p head event (0 when empty)
//   overflow[p]          : sticky, set when an event was dropped on a full queue
//   shake_in[p]          : shake sensor level, only with SHAKE_INPUT_EN defined
// Build option: `define SHAKE_INPUT_EN adds shake_in and code 110 events.
module player_input_router
  import player_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       scan_valid,
  input  logic [7:0]                 scan_code,
  input  logic [NUM_PLAYERS-1:0]     evt_ready,
`ifdef SHAKE_INPUT_EN
  input  logic [NUM_PLAYERS-1:0]     shake_in,
`endif
  output logic [NUM_PLAYERS-1:0]     evt_valid,
  output logic [3*NUM_PLAYERS-1:0]   evt_code,
  output logic [NUM_PLAYERS-1:0]     overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  parse_state_e                 state_q, state_d;
  logic [4*NUM_PLAYERS-1:0]     held_q, held_d;
  logic [NUM_PLAYERS-1:0]       overflow_q, overflow_d;
  logic [NUM_PLAYERS-1:0]       kb_push, push, pop, full, empty;
  logic [3*NUM_PLAYERS-1:0]     push_code, pop_code;
  logic [CW-1:0]                fifo_count [NUM_PLAYERS];
  key_t                         key;
  logic                         in_break;

  assign key      = keymap_lookup(scan_code);
  assign in_break = (state_q == PS_BREAK) || (state_q == PS_EXT_BREAK);

  // E0 only changes which prefix state we sit in; the make/break decision
  // depends solely on whether F0 was seen, so extended keys decode like plain.
  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      if (scan_code == SC_EXT)
        state_d = in_break ? PS_EXT_BREAK : PS_EXT;
      else if (scan_code == SC_BREAK)
        state_d = (state_q == PS_EXT || state_q == PS_EXT_BREAK) ? PS_EXT_BREAK : PS_BREAK;
      else
        state_d = PS_IDLE;
    end
  end

  always_comb begin
    held_d  = held_q;
    kb_push = '0;
    if (scan_valid && scan_code != SC_EXT && scan_code != SC_BREAK && key.hit) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int d = 0; d < 4; d++) begin
          if (key.player == 2'(p) && key.dir == 2'(d)) begin
            if (in_break) begin
              held_d[4*p+d] = 1'b0;
            end else begin
              kb_push[p]    = !held_q[4*p+d];
              held_d[4*p+d] = 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef SHAKE_INPUT_EN
  logic [NUM_PLAYERS-1:0] shake_q, shake_pend_q, shake_pend_d, shake_rise;
  assign shake_rise = shake_in & ~shake_q;
`endif

  // A keyboard event wins the push slot; a coincident shake waits one cycle.
  always_comb begin
    push      = kb_push;
    push_code = '0;
`ifdef SHAKE_INPUT_EN
    shake_pend_d = '0;
`endif
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      push_code[3*p +: 3] = dir_to_evt(key.dir);
`ifdef SHAKE_INPUT_EN
      if (kb_push[p]) begin
        shake_pend_d[p] = shake_rise[p] | shake_pend_q[p];
      end else if (shake_rise[p] || shake_pend_q[p]) begin
        push[p]             = 1'b1;
        push_code[3*p +: 3] = EVT_SHAKE;
      end
`endif
    end
  end

  assign pop        = evt_ready & ~empty;
  assign overflow_d = overflow_q | (push & full & ~pop);
  assign overflow   = overflow_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= PS_IDLE;
      held_q     <= '0;
      overflow_q <= '0;
`ifdef SHAKE_INPUT_EN
      shake_q      <= '0;
      shake_pend_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
`ifdef SHAKE_INPUT_EN
      shake_q      <= shake_in;
      shake_pend_q <= shake_pend_d;
`endif
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    input_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
    ) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push[p]),
      .push_data (push_code[3*p +: 3]),
      .pop       (pop[p]),
      .pop_data  (pop_code[3*p +: 3]),
      .full      (full[p]),
      .empty     (empty[p]),
      .count     (fifo_count[p])
    );
    assign evt_valid[p]        = (fifo_count[p] != '0);
    assign evt_code[3*p +: 3]  = empty[p] ? EVT_NONE : pop_code[3*p +: 3];
  end

endmodule

// File: tb/tb_player_input_router.sv
// Bench for player_input_router: directed scenarios with literal expectations
// plus randomized scan/ready/reset traffic checked every cycle against a
// queue-based model of the key routing rules.
module tb_player_input_router;
  localparam int NP    = 2;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            resetn;
  logic            scan_valid;
  logic [7:0]      scan_code;
  logic [NP-1:0]   evt_ready;
  logic [NP-1:0]   shake_in;
  logic [NP-1:0]   evt_valid;
  logic [3*NP-1:0] evt_code;
  logic [NP-1:0]   overflow;

  int n_chk  = 0;
  int n_fail = 0;

  player_input_router #(.NUM_PLAYERS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .evt_ready  (evt_ready),
`ifdef SHAKE_INPUT_EN
    .shake_in   (shake_in),
`endif
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] keys [16] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74,
                            8'h43, 8'h3B, 8'h42, 8'h4B, 8'h2C, 8'h2B, 8'h34, 8'h33};
  logic [2:0] mq [NP][$];
  bit         mheld [NP][4];
  bit         mbrk;
  bit         movf [NP];
  bit         mshk_prev [NP];
  bit         mshk_pend [NP];

  task automatic model_push(input int p, input logic [2:0] c);
    if (mq[p].size() < DEPTH) mq[p].push_back(c);
    else movf[p] = 1;
  endtask

  always @(posedge clock or negedge resetn) begin
    bit         kb [NP];
    logic [2:0] kbc;
    bit         rise;
    if (!resetn) begin
      mbrk = 0;
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        movf[p] = 0; mshk_prev[p] = 0; mshk_pend[p] = 0;
        for (int d = 0; d < 4; d++) mheld[p][d] = 0;
      end
    end else begin
      kbc = 3'd0;
      for (int p = 0; p < NP; p++) kb[p] = 0;
      if (scan_valid) begin
        if (scan_code == 8'hF0) mbrk = 1;
        else if (scan_code != 8'hE0) begin
          for (int i = 0; i < 16; i++) begin
            if (scan_code == keys[i] && i / 4 < NP) begin
              if (mbrk) mheld[i/4][i%4] = 0;
              else begin
                if (!mheld[i/4][i%4]) begin kb[i/4] = 1; kbc = 3'(i % 4 + 1); end
                mheld[i/4][i%4] = 1;
              end
            end
          end
          mbrk = 0;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (mq[p].size() != 0 && evt_ready[p]) void'(mq[p].pop_front());
`ifdef SHAKE_INPUT_EN
        rise = shake_in[p] && !mshk_prev[p];
        mshk_prev[p] = shake_in[p];
`else
        rise = 0;
`endif
        if (kb[p]) begin
          model_push(p, kbc);
          mshk_pend[p] = mshk_pend[p] | rise;
        end else if (rise || mshk_pend[p]) begin
          model_push(p, 3'b110);
          mshk_pend[p] = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [NP-1:0]   ev, eo;
    logic [3*NP-1:0] ec;
    for (int p = 0; p < NP; p++) begin
      ev[p] = mq[p].size() != 0;
      ec[3*p +: 3] = ev[p] ? mq[p][0] : 3'd0;
      eo[p] = movf[p];
    end
    chk("model_evt_valid", 32'(evt_valid), 32'(ev));
    chk("model_evt_code",  32'(evt_code),  32'(ec));
    chk("model_overflow",  32'(overflow),  32'(eo));
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock); #2;
    resetn = 0; scan_valid = 0; scan_code = 8'h00; evt_ready = '0; shake_in = '0;
    @(negedge clock); #2;
    resetn = 1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1; scan_code = b;
    @(negedge clock);
    scan_valid = 0; scan_code = 8'h00;
  endtask

  task automatic pop_expect(input int p, input logic [2:0] code, input string name);
    chk(name, 32'(evt_code[3*p +: 3]), 32'(code));
    evt_ready[p] = 1;
    @(negedge clock);
    evt_ready[p] = 0;
  endtask

  logic [7:0] p1keys [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
  logic [7:0] p0keys [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};

  initial begin
    resetn = 0; scan_valid = 0; scan_code = 8'h00; evt_ready = '0; shake_in = '0;
    repeat (2) @(negedge clock);
    chk("reset_evt_valid", 32'(evt_valid), 32'd0);
    chk("reset_evt_code",  32'(evt_code),  32'd0);
    chk("reset_overflow",  32'(overflow),  32'd0);
    #2 resetn = 1;

    // single make, then pop empties the queue
    send(8'h1D);
    chk("make_1D_valid", 32'(evt_valid), 32'b01);
    chk("make_1D_code",  32'(evt_code[2:0]), 32'b001);
    evt_ready[0] = 1; @(negedge clock); evt_ready[0] = 0;
    chk("pop_1D_empty", 32'(evt_valid[0]), 32'd0);

    // extended make/break and autorepeat suppression for player 1
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_p1_code", 32'(evt_code[5:3]), 32'b001);
    evt_ready[1] = 1; @(negedge clock); evt_ready[1] = 0;
    chk("ext_p1_only_one", 32'(evt_valid[1]), 32'd0);
    send(8'h75); send(8'h75); send(8'h75);
    chk("repeat_p1_valid", 32'(evt_valid[1]), 32'd1);
    evt_ready[1] = 1; @(negedge clock); evt_ready[1] = 0;
    chk("repeat_p1_only_one", 32'(evt_valid[1]), 32'd0);

    // overflow on player 1: four queued, fifth dropped
    do_reset();
    for (int i = 0; i < 4; i++) begin send(p1keys[i]); send(8'hF0); send(p1keys[i]); end
    chk("ovf_before_fifth", 32'(overflow), 32'd0);
    send(8'h75);
    chk("ovf_after_fifth", 32'(overflow), 32'b10);
    for (int i = 0; i < 4; i++) pop_expect(1, 3'(i + 1), "ovf_order");
    chk("ovf_drained", 32'(evt_valid[1]), 32'd0);
    chk("ovf_sticky",  32'(overflow[1]), 32'd1);

    // full player 0 queue, simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) begin send(p0keys[i]); send(8'hF0); send(p0keys[i]); end
    chk("full_head", 32'(evt_code[2:0]), 32'b001);
    evt_ready[0] = 1;
    send(8'h1D);
    evt_ready[0] = 0;
    chk("full_pushpop_ovf", 32'(overflow[0]), 32'd0);
    pop_expect(0, 3'b010, "full_order_0");
    pop_expect(0, 3'b011, "full_order_1");
    pop_expect(0, 3'b100, "full_order_2");
    pop_expect(0, 3'b001, "full_order_3");
    chk("full_drained", 32'(evt_valid[0]), 32'd0);

`ifdef SHAKE_INPUT_EN
    // shake rise coincident with a keyboard push: key first, shake next
    do_reset();
    shake_in[0] = 1;
    send(8'h23);
    @(negedge clock);
    pop_expect(0, 3'b100, "shake_key_first");
    pop_expect(0, 3'b110, "shake_second");
    chk("shake_drained", 32'(evt_valid[0]), 32'd0);
`endif

    // reset after a break prefix: next key is a make
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1B);
    chk("post_reset_make_valid", 32'(evt_valid[0]), 32'd1);
    chk("post_reset_make_code",  32'(evt_code[2:0]), 32'b011);

    // randomized traffic checked by the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 9));
        scan_valid = ($urandom_range(0, 2) != 0);
        if (r < 2)      scan_code = 8'hE0;
        else if (r < 4) scan_code = 8'hF0;
        else if (r < 8) scan_code = keys[$urandom_range(0, 15)];
        else            scan_code = 8'($urandom);
        evt_ready = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
        if ($urandom_range(0, 7) == 0) shake_in = NP'($urandom);
        @(negedge clock);
      end
    end
    scan_valid = 0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
